// File: rtl/demux_dispatcher.sv
// demux_dispatcher: takes one beat at a time from a valid/ready stream, holds it
// in a register and presents it to a single output lane, chosen either by the
// beat's own destination or by a round-robin pointer. A stalled lane is abandoned
// after TIMEOUT cycles: directed beats are dropped, round-robin beats move on.
module demux_dispatcher #(
    parameter int NUM_ELEM = 4,
    parameter int DATA_W   = 8,
    parameter int TIMEOUT  = 15
) (
    input  logic                        clk_i,
    input  logic                        arst_ni,
    input  logic                        cfg_rr_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [DATA_W-1:0]           in_data_i,
    input  logic [$clog2(NUM_ELEM)-1:0] in_dest_i,
    output logic [NUM_ELEM-1:0]         out_valid_o,
    output logic [DATA_W-1:0]           out_data_o,
    input  logic [NUM_ELEM-1:0]         out_ready_i,
    output logic                        err_drop_o,
    output logic [15:0]                 beat_cnt_o
);

    localparam int SEL_W     = $clog2(NUM_ELEM);
    localparam int LANE_SPAN = 2 ** SEL_W;
    localparam int CNT_W     = $clog2(TIMEOUT + 1);

    // One bit per encodable destination; bits at or above NUM_ELEM are clear so
    // out-of-range destinations can be detected without a magnitude compare.
    localparam logic [LANE_SPAN-1:0] DEST_OK  = {LANE_SPAN{1'b1}} >> (LANE_SPAN - NUM_ELEM);
    localparam logic [SEL_W-1:0]     LAST_SEL = SEL_W'(NUM_ELEM - 1);
    // The counter holds completed stall cycles, so the TIMEOUT-th stalled cycle
    // is the one where it already reads TIMEOUT-1.
    localparam logic [CNT_W-1:0]     TMO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {
        IDLE,
        HOLD
    } state_e;

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [SEL_W-1:0]    rrPtr_q, rrPtr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                rrMode_q, rrMode_d;
    logic [CNT_W-1:0]    tmoCnt_q, tmoCnt_d;
    logic [15:0]         beatCnt_q, beatCnt_d;
    logic                errDrop_q, errDrop_d;

    logic                deliver;
    logic                stalled;
    logic                accept;
    logic                destOk;

    // Next lane in round-robin order, wrapping from the last lane back to 0.
    function automatic logic [SEL_W-1:0] nextLane(input logic [SEL_W-1:0] lane);
        if (lane == LAST_SEL) begin
            return '0;
        end
        return lane + SEL_W'(1);
    endfunction

    // Handshake decode: a held beat either leaves this cycle or stalls, and a
    // leaving beat frees the register for a new accept on the same edge.
    always_comb begin
        deliver    = (state_q == HOLD) && out_ready_i[sel_q];
        stalled    = (state_q == HOLD) && !out_ready_i[sel_q];
        in_ready_o = (state_q == IDLE) || deliver;
        accept     = in_valid_i && in_ready_o;
        destOk     = DEST_OK[in_dest_i];
    end

    // Next-state logic: retire or time out the held beat first, then let a new
    // accept (only possible when nothing is stalled) overwrite the hold register.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        rrPtr_d   = rrPtr_q;
        data_d    = data_q;
        rrMode_d  = rrMode_q;
        tmoCnt_d  = tmoCnt_q;
        beatCnt_d = beatCnt_q;
        errDrop_d = 1'b0;

        if (deliver) begin
            beatCnt_d = beatCnt_q + 16'd1;
            state_d   = IDLE;
        end else if (stalled) begin
            if (tmoCnt_q == TMO_LAST) begin
                tmoCnt_d = '0;
                if (rrMode_q) begin
                    sel_d   = rrPtr_q;
                    rrPtr_d = nextLane(rrPtr_q);
                end else begin
                    state_d   = IDLE;
                    errDrop_d = 1'b1;
                end
            end else begin
                tmoCnt_d = tmoCnt_q + CNT_W'(1);
            end
        end

        if (accept) begin
            tmoCnt_d = '0;
            if (cfg_rr_i) begin
                state_d  = HOLD;
                sel_d    = rrPtr_q;
                rrPtr_d  = nextLane(rrPtr_q);
                data_d   = in_data_i;
                rrMode_d = 1'b1;
            end else if (destOk) begin
                state_d  = HOLD;
                sel_d    = in_dest_i;
                rrPtr_d  = nextLane(in_dest_i);
                data_d   = in_data_i;
                rrMode_d = 1'b0;
            end else begin
                errDrop_d = 1'b1;
            end
        end
    end

    // State and datapath registers; reset discards any held beat.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            rrPtr_q   <= '0;
            data_q    <= '0;
            rrMode_q  <= 1'b0;
            tmoCnt_q  <= '0;
            beatCnt_q <= '0;
            errDrop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            rrPtr_q   <= rrPtr_d;
            data_q    <= data_d;
            rrMode_q  <= rrMode_d;
            tmoCnt_q  <= tmoCnt_d;
            beatCnt_q <= beatCnt_d;
            errDrop_q <= errDrop_d;
        end
    end

    // Output lane decode straight from registered state, so it is one-hot or zero.
    always_comb begin
        out_valid_o = '0;
        if (state_q == HOLD) begin
            out_valid_o[sel_q] = 1'b1;
        end
    end

    assign out_data_o = data_q;
    assign err_drop_o = errDrop_q;
    assign beat_cnt_o = beatCnt_q;

endmodule

// File: tb/tb_demux_dispatcher.sv
// tb_demux_dispatcher: directed vectors against a 4-lane instance and a 3-lane
// instance, each expected value worked out by hand from the lane/timeout rules.
module tb_demux_dispatcher;

    logic        clk_i;
    logic        arst_ni;

    // 4-lane instance
    logic        cfg_rr_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [7:0]  in_data_i;
    logic [1:0]  in_dest_i;
    logic [3:0]  out_valid_o;
    logic [7:0]  out_data_o;
    logic [3:0]  out_ready_i;
    logic        err_drop_o;
    logic [15:0] beat_cnt_o;

    // 3-lane instance
    logic        cfgRr3;
    logic        inValid3;
    logic        inReady3;
    logic [7:0]  inData3;
    logic [1:0]  inDest3;
    logic [2:0]  outValid3;
    logic [7:0]  outData3;
    logic [2:0]  outReady3;
    logic        errDrop3;
    logic [15:0] beatCnt3;

    int checks = 0;
    int errors = 0;

    demux_dispatcher #(.NUM_ELEM(4), .DATA_W(8), .TIMEOUT(15)) dut (
        .clk_i       (clk_i),
        .arst_ni     (arst_ni),
        .cfg_rr_i    (cfg_rr_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .in_dest_i   (in_dest_i),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_ready_i (out_ready_i),
        .err_drop_o  (err_drop_o),
        .beat_cnt_o  (beat_cnt_o)
    );

    demux_dispatcher #(.NUM_ELEM(3), .DATA_W(8), .TIMEOUT(15)) dut3 (
        .clk_i       (clk_i),
        .arst_ni     (arst_ni),
        .cfg_rr_i    (cfgRr3),
        .in_valid_i  (inValid3),
        .in_ready_o  (inReady3),
        .in_data_i   (inData3),
        .in_dest_i   (inDest3),
        .out_valid_o (outValid3),
        .out_data_o  (outData3),
        .out_ready_i (outReady3),
        .err_drop_o  (errDrop3),
        .beat_cnt_o  (beatCnt3)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Count one comparison and report it if observed and expected differ.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Drive one beat onto the 4-lane instance's input port.
    task automatic applyStimulus(input logic valid, input logic rr, input logic [1:0] dest, input logic [7:0] data);
        in_valid_i = valid;
        cfg_rr_i   = rr;
        in_dest_i  = dest;
        in_data_i  = data;
    endtask

    // Two-cycle reset pulse with all inputs idle, released just after an edge.
    task automatic doReset();
        applyStimulus(1'b0, 1'b0, 2'd0, 8'h00);
        inValid3 = 1'b0;
        arst_ni  = 1'b0;
        tick();
        tick();
        arst_ni = 1'b1;
    endtask

    initial begin
        logic [1:0] rrLanes [6];
        rrLanes = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        arst_ni     = 1'b0;
        out_ready_i = 4'b1111;
        cfgRr3      = 1'b0;
        inValid3    = 1'b0;
        inData3     = 8'h00;
        inDest3     = 2'd0;
        outReady3   = 3'b111;
        applyStimulus(1'b0, 1'b0, 2'd0, 8'h00);
        #1;

        // Reset state
        checkOutput("rst_valid", 32'(out_valid_o), 32'h0);
        checkOutput("rst_data", 32'(out_data_o), 32'h0);
        checkOutput("rst_err", 32'(err_drop_o), 32'h0);
        checkOutput("rst_cnt", 32'(beat_cnt_o), 32'h0);
        checkOutput("rst_ready", 32'(in_ready_o), 32'h1);
        tick();
        arst_ni = 1'b1;

        // 1: directed, all lanes ready, destinations 2,0,3 back to back
        applyStimulus(1'b1, 1'b0, 2'd2, 8'hA1);
        checkOutput("t1_ready0", 32'(in_ready_o), 32'h1);
        tick();
        checkOutput("t1_valid0", 32'(out_valid_o), 32'h4);
        checkOutput("t1_data0", 32'(out_data_o), 32'hA1);
        applyStimulus(1'b1, 1'b0, 2'd0, 8'hB2);
        checkOutput("t1_ready1", 32'(in_ready_o), 32'h1);
        tick();
        checkOutput("t1_valid1", 32'(out_valid_o), 32'h1);
        checkOutput("t1_data1", 32'(out_data_o), 32'hB2);
        checkOutput("t1_cnt1", 32'(beat_cnt_o), 32'h1);
        applyStimulus(1'b1, 1'b0, 2'd3, 8'hC3);
        checkOutput("t1_ready2", 32'(in_ready_o), 32'h1);
        tick();
        checkOutput("t1_valid2", 32'(out_valid_o), 32'h8);
        checkOutput("t1_data2", 32'(out_data_o), 32'hC3);
        checkOutput("t1_cnt2", 32'(beat_cnt_o), 32'h2);
        applyStimulus(1'b0, 1'b0, 2'd0, 8'h00);
        tick();
        checkOutput("t1_valid_end", 32'(out_valid_o), 32'h0);
        checkOutput("t1_cnt_end", 32'(beat_cnt_o), 32'h3);
        checkOutput("t1_ready_end", 32'(in_ready_o), 32'h1);

        // 2: round-robin, all ready, six beats from a fresh pointer
        doReset();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b1, 2'd3, 8'(8'h10 + i));
            checkOutput("t2_ready", 32'(in_ready_o), 32'h1);
            tick();
            checkOutput("t2_valid", 32'(out_valid_o), 32'h1 << rrLanes[i]);
            checkOutput("t2_data", 32'(out_data_o), 32'(8'h10 + i));
        end
        applyStimulus(1'b0, 1'b0, 2'd0, 8'h00);
        tick();
        checkOutput("t2_valid_end", 32'(out_valid_o), 32'h0);
        checkOutput("t2_cnt", 32'(beat_cnt_o), 32'h6);

        // 3: directed to stalled lane 1 -> 15 cycles valid, then drop pulse
        out_ready_i = 4'b1101;
        applyStimulus(1'b1, 1'b0, 2'd1, 8'h5A);
        tick();
        applyStimulus(1'b0, 1'b0, 2'd0, 8'h00);
        for (int i = 0; i < 15; i++) begin
            checkOutput("t3_valid_hold", 32'(out_valid_o), 32'h2);
            checkOutput("t3_err_hold", 32'(err_drop_o), 32'h0);
            checkOutput("t3_ready_hold", 32'(in_ready_o), 32'h0);
            out_ready_i[0] = ~out_ready_i[0];
            tick();
        end
        checkOutput("t3_valid_drop", 32'(out_valid_o), 32'h0);
        checkOutput("t3_err_drop", 32'(err_drop_o), 32'h1);
        checkOutput("t3_cnt", 32'(beat_cnt_o), 32'h6);
        checkOutput("t3_ready_idle", 32'(in_ready_o), 32'h1);
        tick();
        checkOutput("t3_err_pulse", 32'(err_drop_o), 32'h0);

        // 4: round-robin, lane 0 stalled, lane 1 ready -> retarget keeps data
        doReset();
        out_ready_i = 4'b1110;
        applyStimulus(1'b1, 1'b1, 2'd2, 8'h77);
        tick();
        applyStimulus(1'b0, 1'b0, 2'd0, 8'h00);
        for (int i = 0; i < 15; i++) begin
            checkOutput("t4_valid_hold", 32'(out_valid_o), 32'h1);
            checkOutput("t4_err_hold", 32'(err_drop_o), 32'h0);
            tick();
        end
        checkOutput("t4_valid_retarget", 32'(out_valid_o), 32'h2);
        checkOutput("t4_data_retarget", 32'(out_data_o), 32'h77);
        checkOutput("t4_err_retarget", 32'(err_drop_o), 32'h0);
        checkOutput("t4_ready_retarget", 32'(in_ready_o), 32'h1);
        tick();
        checkOutput("t4_valid_done", 32'(out_valid_o), 32'h0);
        checkOutput("t4_cnt", 32'(beat_cnt_o), 32'h1);
        checkOutput("t4_err_done", 32'(err_drop_o), 32'h0);

        // 5: asynchronous reset while a round-robin beat is held on lane 2
        out_ready_i = 4'b0000;
        applyStimulus(1'b1, 1'b1, 2'd0, 8'h99);
        tick();
        applyStimulus(1'b0, 1'b0, 2'd0, 8'h00);
        checkOutput("t5_valid_hold", 32'(out_valid_o), 32'h4);
        tick();
        #2;
        arst_ni = 1'b0;
        #1;
        checkOutput("t5_valid_async", 32'(out_valid_o), 32'h0);
        checkOutput("t5_cnt_async", 32'(beat_cnt_o), 32'h0);
        tick();
        arst_ni     = 1'b1;
        out_ready_i = 4'b1111;
        applyStimulus(1'b1, 1'b1, 2'd3, 8'h42);
        tick();
        applyStimulus(1'b0, 1'b0, 2'd0, 8'h00);
        checkOutput("t5_valid_after", 32'(out_valid_o), 32'h1);
        checkOutput("t5_data_after", 32'(out_data_o), 32'h42);

        // 6: three lanes, directed destination 3 is out of range
        inValid3 = 1'b1;
        inDest3  = 2'd3;
        inData3  = 8'hE3;
        checkOutput("t6_ready_pre", 32'(inReady3), 32'h1);
        tick();
        inValid3 = 1'b0;
        checkOutput("t6_err", 32'(errDrop3), 32'h1);
        checkOutput("t6_valid_none", 32'(outValid3), 32'h0);
        checkOutput("t6_ready_post", 32'(inReady3), 32'h1);
        inValid3 = 1'b1;
        inDest3  = 2'd2;
        inData3  = 8'hD2;
        tick();
        inValid3 = 1'b0;
        checkOutput("t6_err_clear", 32'(errDrop3), 32'h0);
        checkOutput("t6_valid_lane2", 32'(outValid3), 32'h4);
        checkOutput("t6_data_lane2", 32'(outData3), 32'hD2);
        tick();
        checkOutput("t6_cnt", 32'(beatCnt3), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
